clock_divider: RTL and testbench

Parameterised integer clock divider that derives a slow, glitch-free clock-enable-style square wave from a fast reference clock. In the default build it reduces the system reference to a 10 kHz timebase. The output is fully registered in the `clk_in` domain and feeds downstream timers and sampling logic.

---
 rtl/clock_div_pkg.sv | 24 ++
 rtl/clock_div_counter.sv | 44 ++++
 rtl/clock_divider.sv | 80 ++++++++
 tb/tb_clock_divider.sv | 135 +++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the clock_divider slice: the phase split
// and counter width are both derived from the division ratio.
package clock_div_pkg;

  localparam int CLK_DIV_DEFAULT = 10000;

  // Number of reference cycles spent low in each output period (ceil(D/2)).
  function automatic int clk_div_low(input int divisor);
    return divisor - (divisor / 2);
  endfunction

  // Counter width able to hold 0..divisor-1, never narrower than one bit.
  function automatic int clk_div_cnt_w(input int divisor);
    int w;
    w = $clog2(divisor);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/clock_div_counter.sv
// Modulo-DIVISOR up-counter with asynchronous active-low reset.
// o_wrap flags the terminal count (DIVISOR-1); the next edge returns to 0.
module clock_div_counter
  import clock_div_pkg::*;
#(
  parameter int DIVISOR = CLK_DIV_DEFAULT,
  parameter int CNT_W   = clk_div_cnt_w(DIVISOR)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_wrap;

  // Terminal-count detect and next-count selection; never counts past DIVISOR-1.
  always_comb begin
    w_wrap     = (r_cnt == CNT_MAX);
    w_cnt_next = {CNT_W{1'b0}};
    if (w_wrap) begin
      w_cnt_next = {CNT_W{1'b0}};
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = w_wrap;

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider: produces a registered square wave of period
// DIVISOR reference cycles (low for ceil(D/2), high for floor(D/2)).
// Optional feature macro CLOCK_DIV_TICK_EN adds clk_tick, a one-cycle strobe
// in the cycle right after the counter wraps (i.e. as clk_out falls).
module clock_divider
  import clock_div_pkg::*;
#(
  parameter int DIVISOR = CLK_DIV_DEFAULT,
  parameter int CNT_W   = clk_div_cnt_w(DIVISOR)
) (
  input  logic clk_in,
  input  logic rst,
`ifdef CLOCK_DIV_TICK_EN
  output logic clk_tick,
`endif
  output logic clk_out
);

  localparam int               LOW     = clk_div_low(DIVISOR);
  localparam logic [CNT_W-1:0] LOW_CNT = CNT_W'(LOW);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("clock_divider: DIVISOR must be at least 2");
  end

  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_wrap;
  logic             w_out_next;
  logic             r_clk_out;

  clock_div_counter #(
    .DIVISOR(DIVISOR),
    .CNT_W  (CNT_W)
  ) u_counter (
    .clk_in(clk_in),
    .rst_n (rst),
    .o_cnt (w_cnt),
    .o_wrap(w_wrap)
  );

  // Output level is decided from the count the next edge will load, so the
  // flop changes in the same edge as the counter (one register stage).
  always_comb begin
    w_cnt_next = {CNT_W{1'b0}};
    if (w_wrap) begin
      w_cnt_next = {CNT_W{1'b0}};
    end else begin
      w_cnt_next = w_cnt + CNT_W'(1);
    end
    w_out_next = (w_cnt_next >= LOW_CNT);
  end

  // Glitch-free output flop; forced low at once by reset.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_clk_out <= 1'b0;
    end else begin
      r_clk_out <= w_out_next;
    end
  end

  assign clk_out = r_clk_out;

`ifdef CLOCK_DIV_TICK_EN
  logic r_tick;

  // Period-start strobe: high for the single cycle following the wrap edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
    end
  end

  assign clk_tick = r_tick;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench: five dividers (10000, 5, 2, 8, 4) share one clock and
// reset; each is compared every cycle with an edge-count reference model.
module tb_clock_divider;

  localparam int NDUT = 5;
  localparam int DIVS [NDUT] = '{10000, 5, 2, 8, 4};

  logic            clk_in = 1'b0;
  logic            rst;
  logic [NDUT-1:0] out_v;
  logic [NDUT-1:0] tick_v;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // rising edges since reset release

  always #5 clk_in = ~clk_in;

`ifdef CLOCK_DIV_TICK_EN
  clock_divider #(.DIVISOR(10000)) u_d10000 (.clk_in(clk_in), .rst(rst), .clk_tick(tick_v[0]), .clk_out(out_v[0]));
  clock_divider #(.DIVISOR(5))     u_d5     (.clk_in(clk_in), .rst(rst), .clk_tick(tick_v[1]), .clk_out(out_v[1]));
  clock_divider #(.DIVISOR(2))     u_d2     (.clk_in(clk_in), .rst(rst), .clk_tick(tick_v[2]), .clk_out(out_v[2]));
  clock_divider #(.DIVISOR(8))     u_d8     (.clk_in(clk_in), .rst(rst), .clk_tick(tick_v[3]), .clk_out(out_v[3]));
  clock_divider #(.DIVISOR(4))     u_d4     (.clk_in(clk_in), .rst(rst), .clk_tick(tick_v[4]), .clk_out(out_v[4]));
`else
  assign tick_v = '0;
  clock_divider #(.DIVISOR(10000)) u_d10000 (.clk_in(clk_in), .rst(rst), .clk_out(out_v[0]));
  clock_divider #(.DIVISOR(5))     u_d5     (.clk_in(clk_in), .rst(rst), .clk_out(out_v[1]));
  clock_divider #(.DIVISOR(2))     u_d2     (.clk_in(clk_in), .rst(rst), .clk_out(out_v[2]));
  clock_divider #(.DIVISOR(8))     u_d8     (.clk_in(clk_in), .rst(rst), .clk_out(out_v[3]));
  clock_divider #(.DIVISOR(4))     u_d4     (.clk_in(clk_in), .rst(rst), .clk_out(out_v[4]));
`endif

  // Reference: within each period the first ceil(d/2) edges are low.
  function automatic logic model_out(input int d, input int kk);
    return ((kk % d) >= (d - d / 2)) ? 1'b1 : 1'b0;
  endfunction

  // Reference: tick follows every multiple of d edges, never edge 0.
  function automatic logic model_tick(input int d, input int kk);
    return ((kk > 0) && ((kk % d) == 0)) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk(input string tag, input int d, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s D=%0d edge=%0d observed=%0b expected=%0b", tag, d, k, got, exp);
    end
  endtask

  task automatic check_all(input bit in_reset);
    for (int i = 0; i < NDUT; i++) begin
      chk("clk_out", DIVS[i], out_v[i], in_reset ? 1'b0 : model_out(DIVS[i], k));
`ifdef CLOCK_DIV_TICK_EN
      chk("clk_tick", DIVS[i], tick_v[i], in_reset ? 1'b0 : model_tick(DIVS[i], k));
`endif
    end
  endtask

  // One reference edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk_in);
    if (rst) k++;
    #1;
    check_all(!rst);
  endtask

  initial begin
    int n;
    // Reset hold with the clock running.
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_all(1'b1);
    repeat (5) step();

    // Release between edges; nothing may change before edge 1.
    @(negedge clk_in);
    rst = 1'b1;
    k   = 0;
    #1 check_all(1'b0);

    // Three full periods of the default ratio (covers all smaller ratios too).
    repeat (30000) begin
      step();
      if (k == 4999)  chk("d10000_pre_rise", 10000, out_v[0], 1'b0);
      if (k == 5000)  chk("d10000_rise",     10000, out_v[0], 1'b1);
      if (k == 10000) chk("d10000_fall",     10000, out_v[0], 1'b0);
      if (k == 19999) chk("d10000_high_end", 10000, out_v[0], 1'b1);
      if (k == 2)     chk("d5_edge2_low",    5,     out_v[1], 1'b0);
      if (k == 3)     chk("d5_edge3_rise",   5,     out_v[1], 1'b1);
      if (k == 5)     chk("d5_edge5_fall",   5,     out_v[1], 1'b0);
      if (k == 1)     chk("d2_edge1_high",   2,     out_v[2], 1'b1);
      if (k == 2)     chk("d2_edge2_low",    2,     out_v[2], 1'b0);
    end

    // Directed asynchronous reset while the divide-by-8 output is high.
    n = 0;
    while ((model_out(8, k) !== 1'b1) && (n < 16)) begin
      step();
      n++;
    end
    chk("d8_high_before_reset", 8, out_v[3], 1'b1);
    #2 rst = 1'b0;
    #1 check_all(1'b1);
    chk("d8_async_drop", 8, out_v[3], 1'b0);
    repeat (2) step();
    @(negedge clk_in);
    rst = 1'b1;
    k   = 0;
    repeat (3) step();
    chk("d8_edge3_low", 8, out_v[3], 1'b0);
    step();
    chk("d8_edge4_rise", 8, out_v[3], 1'b1);

    // Randomised run lengths and reset instants within the cycle.
    repeat (8) begin
      n = $urandom_range(1, 60);
      repeat (n) step();
      #($urandom_range(1, 3)) rst = 1'b0;
      #1 check_all(1'b1);
      n = $urandom_range(1, 3);
      repeat (n) step();
      @(negedge clk_in);
      rst = 1'b1;
      k   = 0;
      #1 check_all(1'b0);
    end
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
